// File: rtl/tdm_mux_scanner_pkg.sv
// ---------------------------------------------------------------------------
// tdm_mux_pkg
//   Shared types and constants for the TDM mux scanner.
//   state_t     : controller state (IDLE / BUSY)
//   MODE_MANUAL : single-shot capture of the channel on `sel`
//   MODE_SCAN   : walk every channel enabled in `ch_mask`, ascending
// ---------------------------------------------------------------------------
package tdm_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/tdm_mux_scanner_search.sv
// ---------------------------------------------------------------------------
// mux_ch_search
//   Combinational priority search: the lowest enabled channel strictly above
//   `cur`. With `first` set the search starts below channel 0, so the result
//   is the lowest enabled channel overall.
//   Ports:
//     mask  in  N_CH  channel enable bits
//     cur   in  CW    current channel index
//     first in  1     ignore `cur`, search from the bottom
//     nxt   out CW    next enabled channel (0 when none found)
//     found out 1     a qualifying channel exists
// ---------------------------------------------------------------------------
module mux_ch_search #(
    parameter int N_CH = 16,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CW-1:0]   cur,
    input  logic            first,
    output logic [CW-1:0]   nxt,
    output logic            found
);

    // Walk downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k] && (first || (k > int'(cur)))) begin
                nxt   = CW'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_scanner.sv
// ---------------------------------------------------------------------------
// tdm_mux_scanner
//   Registered N_CH:1 multiplexer with a sequencing controller. Manual mode
//   captures the channel on `sel` once; scan mode walks every channel enabled
//   in `ch_mask` in ascending order. Each captured word is offered on a
//   valid/ready port; one beat per cycle while the consumer is ready.
//   Ports:
//     clk       in  1       rising-edge clock
//     rst       in  1       synchronous active-high reset
//     in        in  N_CH*W  channel k at [k*W +: W]
//     mode      in  1       0 manual, 1 scan (sampled at accepted start)
//     sel       in  CW      manual channel (sampled at accepted start)
//     ch_mask   in  N_CH    scan enables (sampled at accepted start)
//     start     in  1       run request, accepted only while idle
//     out_data  out W       captured word
//     out_ch    out CW      channel index of captured word
//     out_valid out 1       beat valid
//     out_ready in  1       consumer ready
//     busy      out 1       controller not idle
//     done      out 1       one-cycle pulse at end of each run
// ---------------------------------------------------------------------------
module tdm_mux_scanner
    import tdm_mux_pkg::*;
#(
    parameter  int N_CH = 16,
    parameter  int W    = 1,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in,
    input  logic              mode,
    input  logic [CW-1:0]     sel,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              start,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic              mode_q, mode_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [CW-1:0]     out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    // First enabled channel of the live mask (used only at start) and the
    // next enabled channel above the beat currently presented.
    logic [CW-1:0]     first_idx, next_idx;
    logic              first_found, next_found;

    mux_ch_search #(.N_CH(N_CH), .CW(CW)) u_first (
        .mask  (ch_mask),
        .cur   ('0),
        .first (1'b1),
        .nxt   (first_idx),
        .found (first_found)
    );

    mux_ch_search #(.N_CH(N_CH), .CW(CW)) u_next (
        .mask  (mask_q),
        .cur   (out_ch_q),
        .first (1'b0),
        .nxt   (next_idx),
        .found (next_found)
    );

    // Capture request from the controller; the data select is shared by
    // every capture path.
    logic              cap_en;
    logic [CW-1:0]     cap_ch;
    logic [W-1:0]      cap_word;

    // Compare-and-select rather than a computed part-select so a `sel`
    // beyond N_CH-1 (non power-of-two N_CH) reads as zero instead of X.
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cap_ch == CW'(k)) begin
                cap_word = in[k*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        cap_en      = 1'b0;
        cap_ch      = out_ch_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    if (mode == MODE_MANUAL) begin
                        cap_en = 1'b1;
                        cap_ch = sel;
                    end else if (first_found) begin
                        mask_d = ch_mask;
                        cap_en = 1'b1;
                        cap_ch = first_idx;
                    end else begin
                        // Empty scan mask: nothing to send, finish at once.
                        done_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_valid_q && out_ready) begin
                    if ((mode_q == MODE_SCAN) && next_found) begin
                        cap_en = 1'b1;
                        cap_ch = next_idx;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_en) begin
            out_valid_d = 1'b1;
            state_d     = BUSY;
        end
    end

    always_comb begin
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        if (cap_en) begin
            out_ch_d   = cap_ch;
            out_data_d = cap_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            mode_q      <= MODE_MANUAL;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == BUSY);
    assign done      = done_q;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
module tb_tdm_mux_scanner;

    localparam int N_CH = 16;
    localparam int W    = 4;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH*W-1:0] in;
    logic [N_CH*W-1:0] in_ref;
    logic              mode;
    logic [CW-1:0]     sel;
    logic [N_CH-1:0]   ch_mask;
    logic              start;
    logic [W-1:0]      out_data;
    logic [CW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    tdm_mux_scanner #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .mode      (mode),
        .sel       (sel),
        .ch_mask   (ch_mask),
        .start     (start),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".busy"},  32'(busy),      32'd0);
        chk({tag, ".done"},  32'(done),      32'(exp_done));
    endtask

    initial begin
        logic [CW-1:0] exp_ch[3];
        logic [CW-1:0] prev_ch;
        logic [W-1:0]  prev_data;
        logic          prev_stall;
        int            hs;
        int            dones;
        bit            seen_done;

        for (int k = 0; k < N_CH; k++) in_ref[k*W +: W] = W'(k) ^ 4'hA;
        in        = in_ref;
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        ch_mask   = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst.data", 32'(out_data), 32'd0);
        chk("rst.ch",   32'(out_ch),   32'd0);
        chk_idle("rst", 1'b0);
        rst = 1'b0;
        step();

        // Manual capture of channel 5, held under backpressure, then accepted
        mode = 1'b0; sel = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("man.valid", 32'(out_valid), 32'd1);
        chk("man.busy",  32'(busy),      32'd1);
        chk("man.ch",    32'(out_ch),    32'd5);
        chk("man.data",  32'(out_data),  32'hF);
        in = '0;  // data already captured must not follow `in`
        step();
        chk("man.hold_data",  32'(out_data),  32'hF);
        chk("man.hold_valid", 32'(out_valid), 32'd1);
        in = in_ref;
        out_ready = 1'b1;
        step();
        chk_idle("man.end", 1'b1);
        step();
        chk("man.done_once", 32'(done), 32'd0);

        // Full scan, ready held high
        mode = 1'b1; ch_mask = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            chk($sformatf("full.ch%0d", k),    32'(out_ch),    32'(k));
            chk($sformatf("full.data%0d", k),  32'(out_data),  32'(k ^ 'hA));
            chk($sformatf("full.valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("full.done%0d", k),  32'(done),      32'd0);
            step();
        end
        chk_idle("full.end", 1'b1);
        step();

        // Sparse scan with ready toggling 0/1
        exp_ch[0] = 4'd0; exp_ch[1] = 4'd5; exp_ch[2] = 4'd15;
        ch_mask = 16'h8021; start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        hs = 0; dones = 0; prev_stall = 1'b0; prev_ch = '0; prev_data = '0;
        seen_done = 1'b0;
        for (int i = 0; i < 12 && !seen_done; i++) begin
            out_ready = i[0];
            if (done) begin
                dones++;
                seen_done = 1'b1;
                chk("sparse.end_valid", 32'(out_valid), 32'd0);
            end else begin
                if (prev_stall) begin
                    chk("sparse.stable_ch",   32'(out_ch),   32'(prev_ch));
                    chk("sparse.stable_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (hs < 3) begin
                        chk($sformatf("sparse.ch%0d", hs),   32'(out_ch),   32'(exp_ch[hs]));
                        chk($sformatf("sparse.data%0d", hs), 32'(out_data), 32'(exp_ch[hs] ^ 4'hA));
                    end
                    hs++;
                end
                prev_stall = out_valid && !out_ready;
                prev_ch    = out_ch;
                prev_data  = out_data;
            end
            step();
        end
        chk("sparse.handshakes", 32'(hs),        32'd3);
        chk("sparse.done_seen",  32'(seen_done), 32'd1);
        out_ready = 1'b1;

        // Empty mask: no beat, done next cycle
        ch_mask = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk_idle("empty", 1'b1);
        step();
        chk_idle("empty.after", 1'b0);

        // Inputs changed while busy are ignored; start in done cycle accepted
        mode = 1'b1; ch_mask = 16'h0012; start = 1'b1;
        step();
        chk("ign.ch1", 32'(out_ch), 32'd1);
        mode = 1'b0; sel = 4'd9; ch_mask = 16'hFFFF; start = 1'b1;
        step();
        chk("ign.ch4",   32'(out_ch),   32'd4);
        chk("ign.data4", 32'(out_data), 32'(4'd4 ^ 4'hA));
        step();
        chk_idle("ign.done", 1'b1);
        step();
        start = 1'b0;
        chk("ign.relaunch_valid", 32'(out_valid), 32'd1);
        chk("ign.relaunch_ch",    32'(out_ch),    32'd9);
        chk("ign.relaunch_data",  32'(out_data),  32'h3);
        chk("ign.relaunch_done",  32'(done),      32'd0);
        step();
        chk_idle("ign.relaunch_end", 1'b1);
        step();

        // Reset mid-scan aborts without a done pulse
        mode = 1'b1; ch_mask = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rst2.pre_ch", 32'(out_ch), 32'd2);
        rst = 1'b1;
        step();
        chk("rst2.data", 32'(out_data), 32'd0);
        chk("rst2.ch",   32'(out_ch),   32'd0);
        chk_idle("rst2", 1'b0);
        step();
        rst = 1'b0;
        chk_idle("rst2.hold", 1'b0);
        step();
        chk_idle("rst2.after", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
